mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Parametrised successor to the single-port unified CPU memory. It provides:
- a registered instruction-fetch port;
- a handshaked data port with configurable wait states;
- a streaming program loader that replaces file-based initialisation.

It sits between the CPU core, the fetch/execute sequencer and the external program loader.

Parameters:
INSTR_SIZE, 16, instruction word width and storage word width
DATA_SIZE, 8, data-port width; must be <= INSTR_SIZE
ADDR_SIZE, 8, address width; depth = 2**ADDR_SIZE words
WAIT_STATES, 1, extra cycles between data request acceptance and d_ack (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_en  in  1  fetch request
if_addr  in  ADDR_SIZE  fetch address
if_data  out  INSTR_SIZE  fetched word
if_valid  out  1  if_data valid this cycle
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_SIZE  data address
d_wdata  in  DATA_SIZE  write data
d_rdata  out  DATA_SIZE  read data
d_ack  out  1  one-cycle completion pulse
ld_en  in  1  loader mode
ld_valid  in  1  loader word valid
ld_data  in  INSTR_SIZE  loader word
ld_ready  out  1  loader word accepted when ld_valid & ld_ready
ld_done  out  1  all 2**ADDR_SIZE words loaded

Behaviour:
- Reset (async, rst_n=0): all outputs 0, data FSM to IDLE, loader pointer 0. Memory contents are untouched; no reset loop over the array.
- Fetch:
  - if_en=1 and ld_en=0 at edge N: if_data = mem[if_addr] and if_valid=1 after edge N.
  - Otherwise if_valid=0 and if_data holds its value.
- Data FSM states: IDLE, WAIT, ACK.
  - IDLE: d_req=1 and ld_en=0 → latch d_we/d_addr/d_wdata. Go to WAIT if WAIT_STATES>0, else ACK.
  - WAIT: down-counter loaded with WAIT_STATES-1; go to ACK when it reaches 0.
  - ACK: d_ack=1 for exactly one cycle, then IDLE. A new request may be accepted the cycle after ACK.
  - Acceptance-to-d_ack latency = WAIT_STATES+1 cycles.
  - Write: mem[addr] <= {zeros, wdata} (zero-extended) on the edge entering ACK.
  - Read: d_rdata = mem[addr][DATA_SIZE-1:0], updated on the edge entering ACK and held until the next read ack.
  - Request inputs are ignored outside IDLE.
- Same-cycle fetch and data write to the same address: fetch returns the old word (read-before-write). The next fetch sees the new word.
- Loader:
  - ld_ready = ld_en & ~ld_done & (data FSM == IDLE). An in-flight data transaction always completes first.
  - Each ld_valid & ld_ready writes ld_data to mem[ptr], then ptr++.
  - When ptr wraps from 2**ADDR_SIZE-1, ld_done=1 and ld_ready=0. Further ld_valid is ignored.
  - While ld_en=1, fetch and new data requests are blocked.
  - ld_en=0: ptr=0, ld_done=0 on the next edge. A partial load leaves the already-written words intact.
- Priority per edge: loader write > data write. Both are guaranteed never to coincide by the ld_ready gating.
- Reset mid-transaction: the pending write is dropped if it has not yet reached ACK, d_ack is not issued, and ld_done clears.

Test Plan:
- Reset mid-WAIT (ADDR_SIZE=8, WAIT_STATES=2): write 0x5A to 0x10, assert rst_n=0 during WAIT → d_ack never pulses; later read of 0x10 returns its pre-reset value.
- Loader: ld_en=1, stream 256 words 0x0000..0x00FF with ld_valid gaps → ld_done=1 after the 256th; fetch of 0x7F after ld_en=0 returns 0x007F with if_valid 1 cycle later.
- Data write/read, WAIT_STATES=2: write 0xA5 to 0x20 → d_ack exactly 3 cycles after acceptance; read 0x20 → d_rdata=0xA5 with d_ack; fetch 0x20 → if_data=0x00A5 (zero-extended).
- WAIT_STATES=0: back-to-back requests → one d_ack every 2 cycles; d_req held during ACK is not double-accepted.
- Collision: fetch 0x30 and data-write commit 0x30 on the same edge → if_data is the old word; the next fetch returns the new word.
- Blocking: ld_en raised during a pending read → read completes with d_ack before ld_ready rises; if_en with ld_en=1 → if_valid stays 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: unified CPU memory with a registered instruction-fetch port,
// a handshaked data port with configurable wait states, and a streaming
// program loader.
//
// Handshakes:
//   data port : a request is taken when d_req=1 while the data FSM is IDLE and
//               ld_en=0; d_ack pulses for exactly one cycle when it completes,
//               WAIT_STATES+1 cycles after the request cycle.
//   loader    : a word transfers on every rising edge where ld_valid & ld_ready.
module mem_ctrl #(
  parameter int INSTR_SIZE  = 16,
  parameter int DATA_SIZE   = 8,
  parameter int ADDR_SIZE   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_en,
  input  logic [ADDR_SIZE-1:0]  if_addr,
  output logic [INSTR_SIZE-1:0] if_data,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_SIZE-1:0]  d_addr,
  input  logic [DATA_SIZE-1:0]  d_wdata,
  output logic [DATA_SIZE-1:0]  d_rdata,
  output logic                  d_ack,
  input  logic                  ld_en,
  input  logic                  ld_valid,
  input  logic [INSTR_SIZE-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done
);

  localparam int DEPTH = 2**ADDR_SIZE;
  // Counter preload so that WAIT is occupied for exactly WAIT_STATES cycles.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    lat_we;
  logic [ADDR_SIZE-1:0]    lat_addr;
  logic [DATA_SIZE-1:0]    lat_wdata;
  logic                    accept;
  logic                    commit;
  logic                    cmt_we;
  logic [ADDR_SIZE-1:0]    cmt_addr;
  logic [DATA_SIZE-1:0]    cmt_wdata;
  logic [ADDR_SIZE-1:0]    ptr;
  logic                    ld_fire;
  logic [INSTR_SIZE-1:0]   mem [DEPTH];

  assign accept  = (state == S_IDLE) && d_req && !ld_en;
  assign ld_ready = ld_en && !ld_done && (state == S_IDLE);
  assign ld_fire  = ld_valid && ld_ready;
  assign d_ack    = (state == S_ACK);

  // Transaction commits on the edge that enters ACK. With zero wait states
  // that is the accepting edge itself, so the live request fields are used.
  assign commit    = (state_next == S_ACK) && (state != S_ACK);
  assign cmt_we    = (state == S_IDLE) ? d_we    : lat_we;
  assign cmt_addr  = (state == S_IDLE) ? d_addr  : lat_addr;
  assign cmt_wdata = (state == S_IDLE) ? d_wdata : lat_wdata;

  // Data FSM next-state and wait counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
          cnt_next   = WS_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_ACK;
        else             cnt_next   = cnt - 4'd1;
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Data FSM state, counter and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
      end
    end
  end

  // Read data register: updated only when a read commits, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  d_rdata <= '0;
    else if (commit && !cmt_we)  d_rdata <= mem[cmt_addr][DATA_SIZE-1:0];
  end

  // Storage array writes; loader has priority (ld_ready gating keeps them apart).
  always_ff @(posedge clk) begin
    if (ld_fire)                mem[ptr]      <= ld_data;
    else if (commit && cmt_we)  mem[cmt_addr] <= INSTR_SIZE'(cmt_wdata);
  end

  // Registered instruction fetch; reads the pre-edge contents (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_data  <= '0;
      if_valid <= 1'b0;
    end else if (if_en && !ld_en) begin
      if_data  <= mem[if_addr];
      if_valid <= 1'b1;
    end else begin
      if_valid <= 1'b0;
    end
  end

  // Loader pointer and completion flag; leaving loader mode rearms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      ld_done <= 1'b0;
    end else if (!ld_en) begin
      ptr     <= '0;
      ld_done <= 1'b0;
    end else if (ld_fire) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) ld_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: dut_a uses WAIT_STATES=2, dut_b uses WAIT_STATES=0.
// Drivers push expected responses; a negedge monitor pops and compares.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_en;
  logic [7:0]  if_addr;
  logic        d_req_a, d_req_b;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [7:0]  d_wdata;
  logic        ld_en, ld_valid;
  logic [15:0] ld_data;

  logic [15:0] if_data_a, if_data_b;
  logic        if_valid_a, if_valid_b;
  logic [7:0]  d_rdata_a, d_rdata_b;
  logic        d_ack_a, d_ack_b;
  logic        ld_ready_a, ld_ready_b;
  logic        ld_done_a, ld_done_b;

  typedef struct packed {logic rd; logic [7:0] data; logic [31:0] cyc;} d_exp_t;
  typedef struct packed {logic [15:0] data; logic [31:0] cyc;} f_exp_t;

  d_exp_t      exp_a_q[$];
  d_exp_t      exp_b_q[$];
  f_exp_t      exp_f_q[$];
  d_exp_t      ea, eb;
  f_exp_t      ef;
  logic [31:0] cyc = 0;
  int          n_test = 0;
  int          n_fail = 0;

  mem_ctrl #(.INSTR_SIZE(16), .DATA_SIZE(8), .ADDR_SIZE(8), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_en(if_en), .if_addr(if_addr),
    .if_data(if_data_a), .if_valid(if_valid_a), .d_req(d_req_a), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata_a), .d_ack(d_ack_a),
    .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_a), .ld_done(ld_done_a)
  );

  mem_ctrl #(.INSTR_SIZE(16), .DATA_SIZE(8), .ADDR_SIZE(8), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_en(if_en), .if_addr(if_addr),
    .if_data(if_data_b), .if_valid(if_valid_b), .d_req(d_req_b), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata_b), .d_ack(d_ack_b),
    .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_b), .ld_done(ld_done_b)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents an output.
  always @(negedge clk) begin
    if (d_ack_a === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        n_test++; n_fail++;
        $display("FAIL unexpected_ack_a: got d_ack at cycle %0d, expected none", cyc);
      end else begin
        ea = exp_a_q.pop_front();
        check("ack_a_cycle", cyc, ea.cyc);
        if (ea.rd) check("rdata_a", 32'(d_rdata_a), 32'(ea.data));
      end
    end
    if (d_ack_b === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        n_test++; n_fail++;
        $display("FAIL unexpected_ack_b: got d_ack at cycle %0d, expected none", cyc);
      end else begin
        eb = exp_b_q.pop_front();
        check("ack_b_cycle", cyc, eb.cyc);
        if (eb.rd) check("rdata_b", 32'(d_rdata_b), 32'(eb.data));
      end
    end
    if (if_valid_a === 1'b1) begin
      if (exp_f_q.size() == 0) begin
        n_test++; n_fail++;
        $display("FAIL unexpected_fetch: got if_valid at cycle %0d, expected none", cyc);
      end else begin
        ef = exp_f_q.pop_front();
        check("fetch_cycle", cyc, ef.cyc);
        check("fetch_data", 32'(if_data_a), 32'(ef.data));
      end
    end
  end

  // Driver: one data transaction on dut_a (sel=0) or dut_b (sel=1).
  task automatic data_op(input bit sel, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
    @(negedge clk);
    d_we = we; d_addr = addr; d_wdata = wdata;
    if (sel) d_req_b = 1'b1; else d_req_a = 1'b1;
    @(posedge clk); #1;
    if (sel) exp_b_q.push_back('{rd: ~we, data: exp_rd, cyc: cyc});
    else     exp_a_q.push_back('{rd: ~we, data: exp_rd, cyc: cyc + 2});
    @(negedge clk);
    d_req_a = 1'b0; d_req_b = 1'b0;
  endtask

  // Driver: one fetch on dut_a.
  task automatic fetch(input logic [7:0] addr, input logic [15:0] exp_d);
    @(negedge clk);
    if_en = 1'b1; if_addr = addr;
    @(posedge clk); #1;
    exp_f_q.push_back('{data: exp_d, cyc: cyc});
    @(negedge clk);
    if_en = 1'b0;
  endtask

  // Bounded wait until every outstanding expectation has been consumed.
  task automatic wait_empty();
    for (int k = 0; k < 20; k++) begin
      if (exp_a_q.size() == 0 && exp_b_q.size() == 0 && exp_f_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0 || exp_f_q.size() != 0) begin
      n_test++; n_fail++;
      $display("FAIL response_timeout: got %0d/%0d/%0d pending, expected 0",
               exp_a_q.size(), exp_b_q.size(), exp_f_q.size());
      exp_a_q.delete(); exp_b_q.delete(); exp_f_q.delete();
    end
  endtask

  initial begin
    int not_ready;
    int early;
    int seen;
    rst_n = 1'b0; if_en = 1'b0; if_addr = '0; d_req_a = 1'b0; d_req_b = 1'b0;
    d_we = 1'b0; d_addr = '0; d_wdata = '0; ld_en = 1'b0; ld_valid = 1'b0; ld_data = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_if_valid", 32'(if_valid_a), 0);
    check("rst_if_data", 32'(if_data_a), 0);
    check("rst_d_ack", 32'(d_ack_a | d_ack_b), 0);
    check("rst_d_rdata", 32'(d_rdata_a), 0);
    check("rst_ld_done", 32'(ld_done_a), 0);
    check("rst_ld_ready", 32'(ld_ready_a), 0);
    rst_n = 1'b1;

    // Loader: 256 words 0x0000..0x00FF with random gaps; one blocked fetch.
    ld_en = 1'b1;
    not_ready = 0;
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ld_valid = 1'b1; ld_data = 16'(i);
      if (i == 255) check("ld_done_before_last", 32'(ld_done_a), 0);
      if (!ld_ready_a || !ld_ready_b) not_ready++;
      if (i == 100) begin if_en = 1'b1; if_addr = 8'h05; end
      @(negedge clk);
      if (i == 100) begin
        check("fetch_blocked_in_load", 32'(if_valid_a), 0);
        if_en = 1'b0;
      end
    end
    check("ld_ready_during_load", 32'(not_ready), 0);
    check("ld_done_after_256", 32'(ld_done_a), 1);
    check("ld_ready_after_done", 32'(ld_ready_a), 0);
    ld_data = 16'hFFFF;
    repeat (2) @(negedge clk);
    ld_valid = 1'b0;
    check("ld_done_held", 32'(ld_done_a), 1);
    ld_en = 1'b0;
    @(negedge clk);
    check("ld_done_clear", 32'(ld_done_a), 0);
    fetch(8'h7F, 16'h007F);
    fetch(8'h00, 16'h0000);
    fetch(8'hFF, 16'h00FF);
    wait_empty();

    // Data write/read with two wait states.
    data_op(1'b0, 1'b1, 8'h20, 8'hA5, 8'h00);
    wait_empty();
    data_op(1'b0, 1'b0, 8'h20, 8'h00, 8'hA5);
    wait_empty();
    fetch(8'h20, 16'h00A5);
    data_op(1'b0, 1'b0, 8'h21, 8'h00, 8'h21);
    wait_empty();

    // Reset mid-WAIT drops the pending write and issues no ack.
    @(negedge clk);
    d_req_a = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h5A;
    @(negedge clk);
    d_req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_d_ack", 32'(d_ack_a), 0);
    check("midrst_d_rdata", 32'(d_rdata_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    data_op(1'b0, 1'b0, 8'h10, 8'h00, 8'h10);
    wait_empty();

    // Collision: fetch 0x30 on the same edge the write to 0x30 commits.
    @(negedge clk);
    d_req_a = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 8'hC3;
    @(posedge clk); #1;
    exp_a_q.push_back('{rd: 1'b0, data: 8'h00, cyc: cyc + 2});
    @(negedge clk);
    d_req_a = 1'b0;
    @(negedge clk);
    if_en = 1'b1; if_addr = 8'h30;
    @(posedge clk); #1;
    exp_f_q.push_back('{data: 16'h0030, cyc: cyc});
    @(negedge clk);
    if_en = 1'b0;
    wait_empty();
    fetch(8'h30, 16'h00C3);
    wait_empty();

    // Blocking: ld_en raised during a pending read.
    @(negedge clk);
    d_req_a = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    @(posedge clk); #1;
    exp_a_q.push_back('{rd: 1'b1, data: 8'hA5, cyc: cyc + 2});
    @(negedge clk);
    d_req_a = 1'b0; ld_en = 1'b1; if_en = 1'b1; if_addr = 8'h20;
    early = 0; seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (d_ack_a) begin
        seen = 1;
        check("ld_ready_at_ack", 32'(ld_ready_a), 0);
      end else if (ld_ready_a) early++;
    end
    check("blocked_read_acked", 32'(seen), 1);
    check("ld_ready_early", 32'(early), 0);
    @(negedge clk);
    check("ld_ready_after_ack", 32'(ld_ready_a), 1);
    check("fetch_blocked", 32'(if_valid_a), 0);
    if_en = 1'b0;
    d_req_a = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'hEE;
    repeat (3) @(negedge clk);
    d_req_a = 1'b0;
    @(negedge clk);
    ld_en = 1'b0;
    data_op(1'b0, 1'b0, 8'h40, 8'h00, 8'h40);
    wait_empty();

    // Zero wait states: held d_req gives one ack every 2 cycles.
    data_op(1'b1, 1'b1, 8'h01, 8'h77, 8'h00);
    wait_empty();
    @(negedge clk);
    d_req_b = 1'b1; d_we = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d_addr = 8'(k); d_wdata = 8'(8'h10 + k);
      @(posedge clk); #1;
      if (k % 2 == 0) exp_b_q.push_back('{rd: 1'b0, data: 8'h00, cyc: cyc});
      @(negedge clk);
    end
    d_req_b = 1'b0;
    wait_empty();
    data_op(1'b1, 1'b0, 8'h00, 8'h00, 8'h10);
    data_op(1'b1, 1'b0, 8'h01, 8'h00, 8'h77);
    data_op(1'b1, 1'b0, 8'h02, 8'h00, 8'h12);
    data_op(1'b1, 1'b0, 8'h03, 8'h00, 8'h03);
    data_op(1'b1, 1'b0, 8'h04, 8'h00, 8'h14);
    wait_empty();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
